traffic_phase_controller: RTL and testbench

TRAFFIC_PHASE_CONTROLLER -- requirements
Module: traffic_phase_controller

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/phase_timer.sv | 40 ++++
 rtl/traffic_phase_controller.sv | 138 +++++++++++++
 tb/tb_traffic_phase_controller.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encoding, light bit positions and default durations
package traffic_pkg;

    // Phase encoding kept as plain 2-bit constants so legacy tools see fixed values.
    typedef logic [1:0] phase_t;

    localparam phase_t ST_GREEN  = 2'd0;
    localparam phase_t ST_YELLOW = 2'd1;
    localparam phase_t ST_ALLRED = 2'd2;

    // Bit positions inside one approach's {red,yellow,green} triple.
    localparam int LT_GREEN  = 0;
    localparam int LT_YELLOW = 1;
    localparam int LT_RED    = 2;

    // Durations are "value + 1" ticks because the countdown includes zero.
    localparam int DEF_GREEN_T  = 9;
    localparam int DEF_YELLOW_T = 2;
    localparam int DEF_ALLRED_T = 1;

    function automatic logic [2:0] light_triple(input int pos);
        logic [2:0] t;
        t = 3'b001 << pos;
        return t;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable phase countdown with zero flag
// Ports: clk, rst_n (async active-low), load/load_val (reload), dec_en (count down),
//        count (current value), zero (count == 0).
module phase_timer #(
    parameter int               CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec_en,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec_en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_phase_controller.sv
// rtl/traffic_phase_controller.sv - round-robin traffic light phase FSM with demand skip
// Ports: clk, rst_n (async active-low), tick (1 s enable), hold (freeze),
//        demand[N_WAY] (per-approach request), lights[3*N_WAY] ({r,y,g} per approach),
//        anode[N_WAY] (active-low approach select), count (remaining ticks), active (approach index).
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int N_WAY    = 4,
    parameter int CNT_W    = 4,
    parameter int GREEN_T  = DEF_GREEN_T,
    parameter int YELLOW_T = DEF_YELLOW_T,
    parameter int ALLRED_T = DEF_ALLRED_T
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       hold,
    input  logic [N_WAY-1:0]           demand,
    output logic [3*N_WAY-1:0]         lights,
    output logic [N_WAY-1:0]           anode,
    output logic [CNT_W-1:0]           count,
    output logic [$clog2(N_WAY)-1:0]   active
);

    localparam int AW = $clog2(N_WAY);
    localparam logic [2:0] RED_TRIPLE = light_triple(LT_RED);

    if ((GREEN_T > (2**CNT_W) - 1) || (YELLOW_T > (2**CNT_W) - 1) ||
        (ALLRED_T > (2**CNT_W) - 1)) begin : g_bad_duration
        $error("traffic_phase_controller: a phase duration does not fit in CNT_W bits");
    end

    if ((N_WAY < 2) || (N_WAY > 8)) begin : g_bad_n_way
        $error("traffic_phase_controller: N_WAY must be in 2..8");
    end

    phase_t          state_q;
    phase_t          state_d;
    logic [AW-1:0]   active_q;
    logic [AW-1:0]   active_d;
    logic [AW-1:0]   next_active;
    logic [AW-1:0]   cand;
    logic            found;
    logic            step;
    logic            timer_zero;
    logic            timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic            timer_dec;
    logic [2:0]      active_triple;

    // hold overrides tick: nothing moves unless a tick arrives while not held.
    assign step      = tick && !hold;
    assign timer_dec = step && !timer_zero;

    phase_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (CNT_W'(GREEN_T))
    ) u_phase_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .dec_en   (timer_dec),
        .count    (count),
        .zero     (timer_zero)
    );

    // Rotating search starting one past the current approach; the current
    // approach is examined last so a lone self-demand keeps it.
    always_comb begin
        next_active = AW'((int'(active_q) + 1) % N_WAY);
        found       = 1'b0;
        cand        = '0;
        for (int k = 1; k <= N_WAY; k++) begin
            cand = AW'((int'(active_q) + k) % N_WAY);
            if (!found && demand[cand]) begin
                next_active = cand;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        timer_load     = 1'b0;
        timer_load_val = '0;
        if (step && timer_zero) begin
            timer_load = 1'b1;
            case (state_q)
                ST_GREEN: begin
                    state_d        = ST_YELLOW;
                    timer_load_val = CNT_W'(YELLOW_T);
                end
                ST_YELLOW: begin
                    state_d        = ST_ALLRED;
                    timer_load_val = CNT_W'(ALLRED_T);
                end
                ST_ALLRED: begin
                    state_d        = ST_GREEN;
                    timer_load_val = CNT_W'(GREEN_T);
                    active_d       = next_active;
                end
                default: begin
                    state_d        = ST_GREEN;
                    timer_load_val = CNT_W'(GREEN_T);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_GREEN;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        case (state_q)
            ST_GREEN:  active_triple = light_triple(LT_GREEN);
            ST_YELLOW: active_triple = light_triple(LT_YELLOW);
            default:   active_triple = RED_TRIPLE;
        endcase
    end

    // Outputs are pure decodes of registered state, so reset reaches them asynchronously.
    for (genvar g = 0; g < N_WAY; g++) begin : g_way
        assign lights[3*g +: 3] = (active_q == AW'(g)) ? active_triple : RED_TRIPLE;
        assign anode[g]         = (state_q == ST_ALLRED) || (active_q != AW'(g));
    end

    assign active = active_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb/tb_traffic_phase_controller.sv - directed self-checking bench for traffic_phase_controller
module tb_traffic_phase_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        hold;
    logic [3:0]  demand;
    logic [11:0] lights;
    logic [3:0]  anode;
    logic [3:0]  count;
    logic [1:0]  active;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick   (tick),
        .hold   (hold),
        .demand (demand),
        .lights (lights),
        .anode  (anode),
        .count  (count),
        .active (active)
    );

    // st: 0 green, 1 yellow, 2 all-red
    function automatic logic [11:0] exp_lights(input int st, input int act);
        logic [11:0] pat;
        logic [11:0] msk;
        logic [11:0] v;
        if (st == 0)      pat = 12'h001;
        else if (st == 1) pat = 12'h002;
        else              pat = 12'h004;
        msk = 12'h007 << (3 * act);
        v   = (12'h924 & ~msk) | (pat << (3 * act));
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic inv();
        logic [11:0] sh;
        logic [2:0]  tr;
        logic [3:0]  an_exp;
        int          nonred;
        int          nr_idx;
        nonred = 0;
        nr_idx = 0;
        for (int i = 0; i < 4; i++) begin
            sh = lights >> (3 * i);
            tr = sh[2:0];
            chk("onehot_triple", 32'($onehot(tr)), 32'd1);
            if (!tr[2]) begin
                nonred++;
                nr_idx = i;
            end
        end
        chk("nonred_le1", 32'(nonred <= 1), 32'd1);
        if (nonred == 0) begin
            chk("anode_allred", 32'(anode), 32'hF);
        end else begin
            an_exp = ~(4'b0001 << nr_idx);
            chk("nonred_is_active", 32'(active), 32'(nr_idx));
            chk("anode_active", 32'(anode), 32'(an_exp));
        end
    endtask

    task automatic idle_clk();
        @(negedge clk);
        inv();
    endtask

    task automatic do_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        inv();
        idle_clk();
        idle_clk();
    endtask

    // Checks one full approach up to the last all-red tick (14 ticks); the
    // caller issues the 15th tick so demand can be set first.
    task automatic run_phase(input int a);
        logic [3:0] an_exp;
        an_exp = ~(4'b0001 << a);
        chk("ph_active", 32'(active), 32'(a));
        chk("ph_g_count", 32'(count), 32'd9);
        chk("ph_g_lights", 32'(lights), 32'(exp_lights(0, a)));
        chk("ph_g_anode", 32'(anode), 32'(an_exp));
        for (int k = 1; k <= 9; k++) begin
            do_tick();
            chk("ph_g_dec", 32'(count), 32'(9 - k));
            chk("ph_g_lights_hold", 32'(lights), 32'(exp_lights(0, a)));
        end
        do_tick();
        chk("ph_y_count", 32'(count), 32'd2);
        chk("ph_y_lights", 32'(lights), 32'(exp_lights(1, a)));
        chk("ph_y_anode", 32'(anode), 32'(an_exp));
        do_tick();
        chk("ph_y_c1", 32'(count), 32'd1);
        do_tick();
        chk("ph_y_c0", 32'(count), 32'd0);
        do_tick();
        chk("ph_r_count", 32'(count), 32'd1);
        chk("ph_r_lights", 32'(lights), 32'h924);
        chk("ph_r_anode", 32'(anode), 32'hF);
        chk("ph_r_active", 32'(active), 32'(a));
        do_tick();
        chk("ph_r_c0", 32'(count), 32'd0);
        chk("ph_r_anode2", 32'(anode), 32'hF);
    endtask

    task automatic end_phase(input int exp_act);
        do_tick();
        chk("next_active", 32'(active), 32'(exp_act));
        chk("next_count", 32'(count), 32'd9);
    endtask

    initial begin
        rst_n  = 1'b0;
        tick   = 1'b0;
        hold   = 1'b0;
        demand = 4'b0000;
        repeat (3) @(negedge clk);

        chk("rst_lights", 32'(lights), 32'h921);
        chk("rst_anode", 32'(anode), 32'hE);
        chk("rst_count", 32'(count), 32'd9);
        chk("rst_active", 32'(active), 32'd0);

        // tick present while still in reset must not count
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("rst_tick_ignored", 32'(count), 32'd9);
        rst_n = 1'b1;
        idle_clk();
        idle_clk();
        chk("post_rel_count", 32'(count), 32'd9);

        // full cycle, no demand: 0,1,2,3,0
        run_phase(0); end_phase(1);
        run_phase(1); end_phase(2);
        run_phase(2); end_phase(3);
        run_phase(3); end_phase(0);

        // demand skip and wrap
        run_phase(0); end_phase(1);
        run_phase(1);
        demand = 4'b1001;
        end_phase(3);
        demand = 4'b0000;
        run_phase(3);
        demand = 4'b0010;
        end_phase(1);
        // only the current approach requesting keeps it
        run_phase(1);
        demand = 4'b0010;
        end_phase(1);
        demand = 4'b0000;

        // hold during yellow at count 1
        for (int k = 0; k < 10; k++) do_tick();
        chk("h_y_count", 32'(count), 32'd2);
        do_tick();
        chk("h_y_c1", 32'(count), 32'd1);
        hold = 1'b1;
        for (int k = 0; k < 8; k++) begin
            do_tick();
            chk("hold_count", 32'(count), 32'd1);
            chk("hold_lights", 32'(lights), 32'(exp_lights(1, 1)));
            chk("hold_active", 32'(active), 32'd1);
        end
        hold = 1'b0;
        for (int k = 0; k < 6; k++) idle_clk();
        chk("notick_count", 32'(count), 32'd1);
        chk("notick_lights", 32'(lights), 32'(exp_lights(1, 1)));
        do_tick();
        chk("h_after_c0", 32'(count), 32'd0);
        chk("h_after_y", 32'(lights), 32'(exp_lights(1, 1)));
        do_tick();
        chk("h_allred", 32'(lights), 32'h924);
        chk("h_allred_cnt", 32'(count), 32'd1);
        do_tick();
        end_phase(2);

        // async reset mid-yellow on approach 2
        for (int k = 0; k < 10; k++) do_tick();
        do_tick();
        chk("pre_rst_count", 32'(count), 32'd1);
        chk("pre_rst_lights", 32'(lights), 32'(exp_lights(1, 2)));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_lights", 32'(lights), 32'h921);
        chk("arst_count", 32'(count), 32'd9);
        chk("arst_active", 32'(active), 32'd0);
        chk("arst_anode", 32'(anode), 32'hE);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_clk();
        chk("arst_rel_count", 32'(count), 32'd9);
        do_tick();
        chk("arst_first_tick", 32'(count), 32'd8);
        chk("arst_first_lights", 32'(lights), 32'h921);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
